mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_resp_pkg.sv | 20 ++
 rtl/mem_array.sv | 28 ++
 rtl/mem_responder.sv | 134 +++++++++++++
 tb/tb_mem_responder.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// Shared types and defaults for the mem_responder block.
// Holds the FSM state encoding and default sizing parameters.
package mem_resp_pkg;

   localparam int DEFAULT_DEPTH       = 4096;
   localparam int DEFAULT_WAIT_CYCLES = 2;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      ACCESS,
      RESP
   } state_t;

   typedef enum logic {
      OP_READ,
      OP_WRITE
   } op_t;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM, DEPTH x 16, registered read.
// Contents are never reset.
module mem_array #(
   parameter int DEPTH = 4096,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          en,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [15:0]   wdata,
   output logic [15:0]   rdata
);

   logic [15:0] mem [DEPTH];

   // One access per enabled cycle: commit a write or register a read.
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            mem[addr] <= wdata;
         end else begin
            rdata <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/mem_responder.sv
// Wait-state memory responder: IDLE -> WAIT -> ACCESS -> RESP.
// Optional macro MEM_RANGE_CHECK_EN replaces address wrap with a range check.
module mem_responder
   import mem_resp_pkg::*;
#(
   parameter int DEPTH       = DEFAULT_DEPTH,
   parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] addr_bus,
   input  logic [15:0] data_in,
   input  logic        ram_read,
   input  logic        ram_write,
   output logic [15:0] mem_bus,
   output logic        mem_busy,
   output logic        mem_ready
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [3:0] WAIT_LOAD =
      (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

   state_t      state;
   state_t      state_nx;
   logic [3:0]  wcnt;
   logic [15:0] addr_q;
   logic [15:0] data_q;
   op_t         op_q;
   logic [15:0] bus_q;
   logic [15:0] rd_data;
   logic [15:0] resp_data;
   logic        take;
   logic        addr_hi;
   logic        range_bad;
   logic        rd_now;
   logic        ram_en;
   logic        ram_we;

   assign take    = (state == IDLE) && (ram_read || ram_write);
   assign addr_hi = (int'(addr_q) >= DEPTH);

`ifdef MEM_RANGE_CHECK_EN
   assign range_bad = addr_hi;
`else
   logic unused_addr_hi;
   assign unused_addr_hi = addr_hi;
   assign range_bad      = 1'b0;
`endif

   assign ram_en    = (state == ACCESS) && !range_bad;
   assign ram_we    = ram_en && (op_q == OP_WRITE);
   assign rd_now    = (state == RESP) && (op_q == OP_READ);
   assign resp_data = range_bad ? 16'h0000 : rd_data;

   assign mem_bus   = rd_now ? resp_data : bus_q;
   assign mem_busy  = (state != IDLE);
   assign mem_ready = (state == RESP);

   // Next-state decode; WAIT is skipped when no wait states are configured.
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (take) begin
               state_nx = (WAIT_CYCLES == 0) ? ACCESS : WAIT;
            end
         end
         WAIT: begin
            if (wcnt == 4'd0) begin
               state_nx = ACCESS;
            end
         end
         ACCESS:  state_nx = RESP;
         RESP:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Capture the request when it is accepted; write wins over read.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q <= 16'h0000;
         data_q <= 16'h0000;
         op_q   <= OP_READ;
      end else if (take) begin
         addr_q <= addr_bus;
         data_q <= data_in;
         op_q   <= ram_write ? OP_WRITE : OP_READ;
      end
   end

   // Wait-state down counter, loaded on acceptance.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wcnt <= 4'd0;
      end else if (take) begin
         wcnt <= WAIT_LOAD;
      end else if ((state == WAIT) && (wcnt != 4'd0)) begin
         wcnt <= wcnt - 4'd1;
      end
   end

   // Keep the last completed read visible between reads.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus_q <= 16'h0000;
      end else if (rd_now) begin
         bus_q <= resp_data;
      end
   end

   mem_array #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_array (
      .clk   (clk),
      .en    (ram_en),
      .we    (ram_we),
      .addr  (addr_q[AW-1:0]),
      .wdata (data_q),
      .rdata (rd_data)
   );

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: two instances (2 and 0 wait states).
// Stimulus pushes expected responses; per-instance monitors pop and compare.
module tb_mem_responder;

   typedef struct {
      logic [15:0] data;
      int          due;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_s  [2];
   logic [15:0] addr_s [2];
   logic [15:0] din_s  [2];
   logic        rd_s   [2];
   logic        wr_s   [2];
   logic [15:0] bus    [2];
   logic        busy   [2];
   logic        rdy    [2];

   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t q0[$];
   exp_t q1[$];
   logic [15:0] last_bus [2];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   mem_responder #(.DEPTH(4096), .WAIT_CYCLES(2)) dut_w2 (
      .clk       (clk),
      .rst       (rst_s[0]),
      .addr_bus  (addr_s[0]),
      .data_in   (din_s[0]),
      .ram_read  (rd_s[0]),
      .ram_write (wr_s[0]),
      .mem_bus   (bus[0]),
      .mem_busy  (busy[0]),
      .mem_ready (rdy[0])
   );

   mem_responder #(.DEPTH(4096), .WAIT_CYCLES(0)) dut_w0 (
      .clk       (clk),
      .rst       (rst_s[1]),
      .addr_bus  (addr_s[1]),
      .data_in   (din_s[1]),
      .ram_read  (rd_s[1]),
      .ram_write (wr_s[1]),
      .mem_bus   (bus[1]),
      .mem_busy  (busy[1]),
      .mem_ready (rdy[1])
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic int wait_of(input int d);
      return (d == 0) ? 2 : 0;
   endfunction

   task automatic push(input int d, input logic [15:0] data, input int due);
      exp_t e;
      e.data = data;
      e.due  = due;
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
   endtask

   task automatic monitor(input int d);
      exp_t e;
      int   n;
      n = (d == 0) ? q0.size() : q1.size();
      if (n == 0) begin
         chk($sformatf("d%0d unexpected ready", d), 32'd1, 32'd0);
      end else begin
         e = (d == 0) ? q0.pop_front() : q1.pop_front();
         chk($sformatf("d%0d mem_bus", d), 32'(bus[d]), 32'(e.data));
         chk($sformatf("d%0d latency", d), cyc, e.due);
         chk($sformatf("d%0d busy@ready", d), 32'(busy[d]), 32'd1);
      end
   endtask

   always @(negedge clk) if (!rst_s[0] && rdy[0]) monitor(0);
   always @(negedge clk) if (!rst_s[1] && rdy[1]) monitor(1);

   task automatic wait_ready(input int d);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (rdy[d]) return;
      end
      chk($sformatf("d%0d ready timeout", d), 32'd0, 32'd1);
   endtask

   task automatic do_op(input int d, input bit rd, input bit wr,
                        input logic [15:0] a, input logic [15:0] wd,
                        input logic [15:0] exp_rd);
      @(negedge clk);
      addr_s[d] = a;
      din_s[d]  = wd;
      rd_s[d]   = rd;
      wr_s[d]   = wr;
      @(posedge clk);
      #1;
      if (wr) begin
         push(d, last_bus[d], cyc + wait_of(d) + 1);
      end else begin
         push(d, exp_rd, cyc + wait_of(d) + 1);
         last_bus[d] = exp_rd;
      end
      wait_ready(d);
      rd_s[d] = 1'b0;
      wr_s[d] = 1'b0;
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         rst_s[d]    = 1'b1;
         addr_s[d]   = 16'h0000;
         din_s[d]    = 16'h0000;
         rd_s[d]     = 1'b0;
         wr_s[d]     = 1'b0;
         last_bus[d] = 16'h0000;
      end
      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("d%0d reset busy", d), 32'(busy[d]), 32'd0);
         chk($sformatf("d%0d reset ready", d), 32'(rdy[d]), 32'd0);
         chk($sformatf("d%0d reset bus", d), 32'(bus[d]), 32'h0);
         rst_s[d] = 1'b0;
      end

      // Basic write then read with two wait states.
      do_op(0, 0, 1, 16'h0010, 16'hBEEF, 16'h0);
      do_op(0, 1, 0, 16'h0010, 16'h0000, 16'hBEEF);

      // Both strobes: write wins, mem_bus keeps BEEF.
      do_op(0, 1, 1, 16'h0020, 16'h1234, 16'h0);
      do_op(0, 1, 0, 16'h0020, 16'h0000, 16'h1234);

      // Reset during WAIT aborts the write.
      do_op(0, 0, 1, 16'h0030, 16'h5555, 16'h0);
      @(negedge clk);
      addr_s[0] = 16'h0030;
      din_s[0]  = 16'hAAAA;
      wr_s[0]   = 1'b1;
      @(negedge clk);
      chk("abort in wait busy", 32'(busy[0]), 32'd1);
      rst_s[0] = 1'b1;
      wr_s[0]  = 1'b0;
      @(negedge clk);
      chk("abort busy", 32'(busy[0]), 32'd0);
      chk("abort ready", 32'(rdy[0]), 32'd0);
      chk("abort bus", 32'(bus[0]), 32'h0);
      rst_s[0]    = 1'b0;
      last_bus[0] = 16'h0000;
      @(negedge clk);
      chk("post reset busy", 32'(busy[0]), 32'd0);
      do_op(0, 1, 0, 16'h0030, 16'h0000, 16'h5555);

      // Out-of-range address handling.
      do_op(0, 0, 1, 16'h0005, 16'h0A0A, 16'h0);
      do_op(0, 0, 1, 16'h1005, 16'h00FF, 16'h0);
`ifdef MEM_RANGE_CHECK_EN
      do_op(0, 1, 0, 16'h1005, 16'h0000, 16'h0000);
      do_op(0, 1, 0, 16'h0005, 16'h0000, 16'h0A0A);
`else
      do_op(0, 1, 0, 16'h0005, 16'h0000, 16'h00FF);
      do_op(0, 1, 0, 16'h1005, 16'h0000, 16'h00FF);
`endif

      // Zero wait states: preload, then held read strobe.
      do_op(1, 0, 1, 16'h0001, 16'h1111, 16'h0);
      do_op(1, 0, 1, 16'h0002, 16'h2222, 16'h0);
      @(negedge clk);
      addr_s[1] = 16'h0001;
      rd_s[1]   = 1'b1;
      @(posedge clk);
      #1;
      push(1, 16'h1111, cyc + 1);
      wait_ready(1);
      addr_s[1] = 16'h0002;
      @(posedge clk);
      @(posedge clk);
      #1;
      push(1, 16'h2222, cyc + 1);
      wait_ready(1);
      rd_s[1] = 1'b0;

      repeat (4) @(negedge clk);
      chk("d0 queue drained", 32'(q0.size()), 32'd0);
      chk("d1 queue drained", 32'(q1.size()), 32'd0);
      chk("d1 idle busy", 32'(busy[1]), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
